// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word width, requester indices, arbiter state.
package cpu_pkg;

  localparam int WORD    = 32;
  localparam int REQ_CPU = 0;
  localparam int REQ_EXT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Control part of the transaction captured at the IDLE sample.
  typedef struct packed {
    logic idx;
    logic we;
  } arb_txn_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker; prio only matters when both requesters want in.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Lone requester wins outright; a tie goes to the priority pointer.
  always_comb begin
    gnt_valid = |req;
    if (req[REQ_CPU] && req[REQ_EXT]) gnt_idx = prio;
    else                              gnt_idx = req[REQ_EXT];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the CPU (0) and an external master (1).
// Each grant runs IDLE -> ACCESS -> RESP; ack and rdata are registered.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int WORD = cpu_pkg::WORD,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [WORD-1:0] addr0,
  input  logic [WORD-1:0] addr1,
  input  logic [WORD-1:0] wdata0,
  input  logic [WORD-1:0] wdata1,
  output logic [1:0]      ack,
  output logic [WORD-1:0] rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy
);

  arb_state_t      state_q, state_d;
  logic            prio_q;
  arb_txn_t        txn_q;
  logic [AW-1:0]   addr_q;
  logic [WORD-1:0] wdata_q;
  logic [1:0]      ack_q;
  logic [WORD-1:0] rdata_q;
  logic            gnt_valid, gnt_idx;

  // Byte-offset and upper address bits never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[WORD-1:AW+2], addr0[1:0],
                              addr1[WORD-1:AW+2], addr1[1:0]};

  rr_pick2 u_pick (
    .req      (req),
    .prio     (prio_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: fixed three-cycle walk once a request is seen in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side decode from registered state only; quiet outside ACCESS so
  // a reset that lands mid-ACCESS suppresses the write immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_we    = txn_q.we;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    busy  = (state_q != IDLE);
    ack   = ack_q;
    rdata = rdata_q;
  end

  // Transaction latch, priority pointer, registered ack pulse and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      txn_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (gnt_valid) begin
          txn_q.idx <= gnt_idx;
          txn_q.we  <= we[gnt_idx];
          addr_q    <= gnt_idx ? addr1[AW+1:2] : addr0[AW+1:2];
          wdata_q   <= gnt_idx ? wdata1 : wdata0;
          prio_q    <= ~gnt_idx;
        end
        ACCESS: begin
          ack_q[txn_q.idx] <= 1'b1;
          if (!txn_q.we) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
